rom_string_sender: RTL
======================

Name: rom_string_sender

Overview:
- Sequencer between the synchronous read-only message memory (4-bit address, 8-bit data, null-terminated string) and the UART transmitter.
- On a start pulse it walks the memory from START_ADDR and presents each byte to the transmitter over a valid/ready handshake.
- It stops at the first 0x00 byte, or after the last address.
- It owns the memory address bus and absorbs the memory's 1-cycle read latency.

Parameters:
- ADDR_W, 4, memory address width; last address = 2^ADDR_W-1
- DATA_W, 8, memory/transmit data width
- START_ADDR, 0, first address read after start

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin sending; sampled only in IDLE
- addr_o  out  ADDR_W  address to memory
- data_i  in  DATA_W  memory read data, valid the cycle after addr_o is sampled
- tx_data_o  out  DATA_W  byte to UART transmitter
- tx_valid_o  out  1  tx_data_o holds a byte to send
- tx_ready_i  in  1  transmitter accepts byte when high with tx_valid_o
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of string

Behaviour:
- Interface: one clock, clk_i; asynchronous active-low reset, rst_ni.
- Reset (async, any state): state=IDLE, addr_o=START_ADDR, tx_data_o=0, tx_valid_o=0, done_o=0, busy_o=0.
- All outputs are registered or decoded from the state register. No combinational path from tx_ready_i or data_i to any output.
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE:
  - start_i=1 -> addr_o<=START_ADDR, go FETCH.
  - start_i=0 -> stay.
- FETCH: 1 cycle while the memory samples addr_o -> LOAD.
- LOAD: data_i is valid this cycle.
  - data_i==0 -> DONE; no byte is sent.
  - Otherwise tx_data_o<=data_i, tx_valid_o<=1 -> SEND.
- SEND: tx_valid_o held 1 and tx_data_o held stable until tx_ready_i=1.
  - On the handshake cycle tx_valid_o<=0.
  - If addr_o==2^ADDR_W-1 -> DONE. addr_o does not wrap; the last address acts as an implicit terminator.
  - Else addr_o<=addr_o+1 -> FETCH.
- DONE: done_o=1 for exactly this cycle -> IDLE. addr_o keeps its last value until the next start.
- Latency:
  - start_i sampled at cycle S -> first tx_valid_o at S+3.
  - With tx_ready_i held high, one byte every 3 cycles.
  - Null at LOAD cycle L -> done_o at L+1; IDLE at L+2.
- Simultaneous events:
  - start_i while busy_o=1 is ignored, including in the DONE cycle.
  - tx_ready_i while tx_valid_o=0 is ignored.
- Reset mid-operation:
  - tx_valid_o drops immediately (async); no partial byte is retained.
  - After release, the block waits in IDLE for a new start_i.
- addr_o increment is modulo-free: it never exceeds 2^ADDR_W-1 by construction.

Test Plan:
- Memory model preloaded with "Simple UART EyC" + 0x00 at address 15, tx_ready_i=1, start_i pulse at cycle S:
  - 15 handshakes, bytes 0x53,0x69,0x6D,0x70,0x6C,0x65,0x20,0x55,0x41,0x52,0x54,0x20,0x45,0x79,0x43.
  - Handshakes at S+3, S+6, ..., S+45.
  - done_o high only at S+48; busy_o high S+1..S+48.
- Same memory, tx_ready_i held low for 5 cycles after the first tx_valid_o:
  - tx_valid_o stays 1 and tx_data_o stays 0x53 for all 6 cycles.
  - addr_o stays 0.
  - The next byte 0x69 appears 3 cycles after the handshake.
- Address 0 = 0x00, start_i pulse at S: tx_valid_o never asserts; done_o at S+3; busy_o low at S+4.
- All 16 locations nonzero (0x41..0x50):
  - 16 bytes sent, last 0x50 from address 15.
  - done_o the cycle after the last handshake; addr_o ends at 15 with no wrap to 0.
- start_i pulsed mid-transfer (after the 4th byte) -> ignored: byte sequence unchanged, exactly one done_o.
- rst_ni low during SEND of the 7th byte:
  - tx_valid_o=0, busy_o=0, addr_o=START_ADDR immediately.
  - After release and a new start_i, the full string is sent again from 0x53.
- START_ADDR=7: sends "UART EyC" (8 bytes, first 0x55, last 0x43), then done_o.

Source files
------------

// File: rtl/rom_string_sender_if.sv
// Bundle between the string sequencer, the message ROM read port and the UART transmitter.
// master = sequencer side; slave = the memory/transmitter/control side.
interface rom_string_sender_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start_i;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, data_i, tx_ready_i,
    output addr_o, tx_data_o, tx_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, data_i, tx_ready_i,
    input  addr_o, tx_data_o, tx_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/rom_string_sender.sv
// Walks a null-terminated string in a 1-cycle-latency ROM and hands each byte to the UART (3 cycles/byte).
// tx_valid_o/tx_data_o hold until tx_ready_i; the last address ends the string even without a null.
module rom_string_sender #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rom_string_sender_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= START_ADDR;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            addr_q <= START_ADDR;
            state  <= FETCH;
          end
        end
        // ROM samples addr_q on this edge; data_i is valid in LOAD
        FETCH: state <= LOAD;
        LOAD: begin
          if (bus.data_i == '0) begin
            state <= DONE;
          end else begin
            tx_data_q  <= bus.data_i;
            tx_valid_q <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_ready_i) begin
            tx_valid_q <= 1'b0;
            // last address is an implicit terminator, so addr_q never wraps
            if (addr_q == LAST_ADDR) begin
              state <= DONE;
            end else begin
              addr_q <= addr_q + 1'b1;
              state  <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr_o     = addr_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = (state == DONE);

endmodule
